// File: rtl/pipeline_bus_arbiter_pkg.sv
// pipeline_bus_arbiter_pkg: shared CPU control state encoding, counter type and arbiter defaults
package pipeline_bus_arbiter_pkg;
    localparam logic [1:0] ST_CPU    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_GRANT  = 2'd2;
    localparam logic [1:0] ST_RETURN = 2'd3;
    localparam int DEF_DRAIN_CYCLES = 2;
    localparam int DEF_MAX_GRANT    = 16;
    localparam int DEF_MIN_CPU      = 4;
    localparam int CNT_W            = 8;
    typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/pipeline_bus_arbiter_down_counter.sv
// arb_down_counter: loadable down counter that saturates at zero
module arb_down_counter
    import pipeline_bus_arbiter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  cnt_t load_value,
    input  logic dec,
    output cnt_t value,
    output logic zero
);
    always_ff @(posedge clk)
        if (reset) value <= '0;
        else if (load) value <= load_value;
        else if (dec && !zero) value <= value - 1'b1;
    assign zero = (value == '0);
endmodule

// File: rtl/pipeline_bus_arbiter.sv
// pipeline_bus_arbiter: hands the bus to an external master after draining the fetch pipeline
module pipeline_bus_arbiter
    import pipeline_bus_arbiter_pkg::*;
#(
    parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
    parameter int MAX_GRANT    = DEF_MAX_GRANT,
    parameter int MIN_CPU      = DEF_MIN_CPU
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dma_req,
    input  logic       fetch_suppress_in,
    output logic       bus_request,
    output logic       fetch_suppress,
    output logic       dma_grant,
    output logic       preempt,
    output logic [1:0] arb_state
);
    localparam cnt_t DRAIN_LOAD = cnt_t'(DRAIN_CYCLES - 1);
    localparam cnt_t GRANT_LOAD = cnt_t'(MAX_GRANT - 1);
    // the first CPU cycle already counts toward the cooldown
    localparam cnt_t COOL_LOAD  = cnt_t'(MIN_CPU > 0 ? MIN_CPU - 1 : 0);

    logic [1:0] state, state_nx;
    cnt_t drain_val, grant_val, cool_val;
    logic drain_zero, grant_zero, cool_zero;

    always_comb begin
        state_nx = state;
        case (state)
            ST_CPU:   state_nx = (dma_req && !fetch_suppress_in && cool_zero) ? ST_DRAIN : ST_CPU;
            ST_DRAIN: state_nx = !dma_req ? ST_RETURN : drain_zero ? ST_GRANT : ST_DRAIN;
            ST_GRANT: state_nx = (!dma_req || grant_zero) ? ST_RETURN : ST_GRANT;
            default:  state_nx = ST_CPU;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_CPU;
            preempt <= 1'b0;
        end else begin
            state   <= state_nx;
            preempt <= (state == ST_GRANT) && dma_req && grant_zero;
        end
    end

    arb_down_counter u_drain (
        .clk(clk), .reset(reset),
        .load(state == ST_CPU && state_nx == ST_DRAIN), .load_value(DRAIN_LOAD),
        .dec(state == ST_DRAIN), .value(drain_val), .zero(drain_zero)
    );

    arb_down_counter u_grant (
        .clk(clk), .reset(reset),
        .load(state == ST_DRAIN && state_nx == ST_GRANT), .load_value(GRANT_LOAD),
        .dec(state == ST_GRANT), .value(grant_val), .zero(grant_zero)
    );

    arb_down_counter u_cool (
        .clk(clk), .reset(reset),
        .load(state == ST_RETURN), .load_value(COOL_LOAD),
        .dec(state == ST_CPU), .value(cool_val), .zero(cool_zero)
    );

    assign bus_request    = (state == ST_DRAIN) || (state == ST_GRANT);
    assign fetch_suppress = (state != ST_CPU);
    assign dma_grant      = (state == ST_GRANT);
    assign arb_state      = state;
endmodule
